// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: command FIFO, scan/commit slot table, sample-rate dispatch.
// Define VOICE_STEAL_EN to steal the oldest slot when the table is full (default: drop).
module voice_allocator #(
    parameter int NVOICES    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic [6:0]  o_midi,
    output logic [3:0]  o_slot,
    output logic        o_valid,
    output logic [4:0]  o_active,
    output logic        o_drop
);

    localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  LAST_SLOT = 4'(NVOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_s, pop_s;
    logic          unused_data_s;

    state_t        state_q, state_d;
    logic [3:0]    scan_idx_q, scan_idx_d;
    logic          cmd_on_q, cmd_on_d;
    logic [6:0]    cmd_note_q, cmd_note_d;
    logic          match_hit_q, match_hit_d, empty_hit_q, empty_hit_d, old_hit_q, old_hit_d;
    logic [3:0]    match_idx_q, match_idx_d, empty_idx_q, empty_idx_d, old_idx_q, old_idx_d;
    logic [7:0]    old_age_q, old_age_d;

    logic [6:0]    note_q [NVOICES];
    logic [6:0]    note_d [NVOICES];
    logic [7:0]    age_q  [NVOICES];
    logic [7:0]    age_d  [NVOICES];
    logic          place_s;
    logic [3:0]    tgt_s;
    logic          drop_q, drop_d;
    logic [4:0]    active_q, active_d;

    logic [3:0]    disp_idx_q;
    logic [6:0]    midi_q;
    logic [3:0]    slot_q;
    logic          valid_q;

    assign unused_data_s = ^i_data[7:0];
    assign o_ready  = (count_q != FULL_CNT);
    assign push_s   = i_valid && o_ready;
    assign pop_s    = (state_q == S_IDLE) && (count_q != {(AW + 1){1'b0}});
    assign o_midi   = midi_q;
    assign o_slot   = slot_q;
    assign o_valid  = valid_q;
    assign o_active = active_q;
    assign o_drop   = drop_q;

    // FIFO storage; only the on/off flag and the note are kept
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= {i_data[15], i_data[14:8]};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state, scan bookkeeping and table update applied in COMMIT
    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        cmd_on_d    = cmd_on_q;
        cmd_note_d  = cmd_note_q;
        match_hit_d = match_hit_q;
        match_idx_d = match_idx_q;
        empty_hit_d = empty_hit_q;
        empty_idx_d = empty_idx_q;
        old_hit_d   = old_hit_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        note_d      = note_q;
        age_d       = age_q;
        place_s     = 1'b0;
        tgt_s       = 4'd0;
        drop_d      = 1'b0;
        active_d    = 5'd0;

        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    cmd_on_d    = fifo_mem_q[rd_ptr_q][7];
                    cmd_note_d  = fifo_mem_q[rd_ptr_q][6:0];
                    scan_idx_d  = 4'd0;
                    match_hit_d = 1'b0;
                    empty_hit_d = 1'b0;
                    old_hit_d   = 1'b0;
                    state_d     = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!match_hit_q && note_q[scan_idx_q] == cmd_note_q) begin
                    match_hit_d = 1'b1;
                    match_idx_d = scan_idx_q;
                end
                if (!empty_hit_q && note_q[scan_idx_q] == 7'd0) begin
                    empty_hit_d = 1'b1;
                    empty_idx_d = scan_idx_q;
                end
                // strict compare keeps the lowest index on equal ages
                if (note_q[scan_idx_q] != 7'd0 && (!old_hit_q || age_q[scan_idx_q] > old_age_q)) begin
                    old_hit_d = 1'b1;
                    old_idx_d = scan_idx_q;
                    old_age_d = age_q[scan_idx_q];
                end
                if (scan_idx_q == LAST_SLOT) begin
                    state_d = S_COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + 4'd1;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (cmd_on_q) begin
                    if (cmd_note_q == 7'd0) begin
                        place_s = 1'b0;
                    end else if (match_hit_q) begin
                        place_s = 1'b1;
                        tgt_s   = match_idx_q;
                    end else if (empty_hit_q) begin
                        place_s = 1'b1;
                        tgt_s   = empty_idx_q;
                    end else begin
`ifdef VOICE_STEAL_EN
                        place_s = 1'b1;
                        tgt_s   = old_idx_q;
`else
                        drop_d  = 1'b1;
`endif
                    end
                    for (int i = 0; i < NVOICES; i++) begin
                        if (place_s && 4'(i) == tgt_s) begin
                            note_d[i] = cmd_note_q;
                            age_d[i]  = 8'd0;
                        end else if (place_s && note_q[i] != 7'd0 && age_q[i] != 8'hFF) begin
                            age_d[i] = age_q[i] + 8'd1;
                        end else begin
                            age_d[i] = age_q[i];
                        end
                    end
                end else if (cmd_note_q == 7'h7F) begin
                    for (int i = 0; i < NVOICES; i++) begin
                        note_d[i] = 7'd0;
                        age_d[i]  = 8'd0;
                    end
                end else if (match_hit_q && cmd_note_q != 7'd0) begin
                    note_d[match_idx_q] = 7'd0;
                    age_d[match_idx_q]  = 8'd0;
                end else begin
                    place_s = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < NVOICES; i++) begin
            if (note_d[i] != 7'd0) active_d = active_d + 5'd1;
        end
    end

    // FSM, scan results and command holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            scan_idx_q  <= 4'd0;
            cmd_on_q    <= 1'b0;
            cmd_note_q  <= 7'd0;
            match_hit_q <= 1'b0;
            match_idx_q <= 4'd0;
            empty_hit_q <= 1'b0;
            empty_idx_q <= 4'd0;
            old_hit_q   <= 1'b0;
            old_idx_q   <= 4'd0;
            old_age_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            cmd_on_q    <= cmd_on_d;
            cmd_note_q  <= cmd_note_d;
            match_hit_q <= match_hit_d;
            match_idx_q <= match_idx_d;
            empty_hit_q <= empty_hit_d;
            empty_idx_q <= empty_idx_d;
            old_hit_q   <= old_hit_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
        end
    end

    // Slot table, active count and drop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NVOICES; i++) begin
                note_q[i] <= 7'd0;
                age_q[i]  <= 8'd0;
            end
            active_q <= 5'd0;
            drop_q   <= 1'b0;
        end else begin
            note_q   <= note_d;
            age_q    <= age_d;
            active_q <= active_d;
            drop_q   <= drop_d;
        end
    end

    // Dispatch samples the pre-commit table at the sample strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_idx_q <= 4'd0;
            midi_q     <= 7'd0;
            slot_q     <= 4'd0;
            valid_q    <= 1'b0;
        end else if (clk_en) begin
            midi_q     <= note_q[disp_idx_q];
            slot_q     <= disp_idx_q;
            valid_q    <= (note_q[disp_idx_q] != 7'd0);
            disp_idx_q <= (disp_idx_q == LAST_SLOT) ? 4'd0 : disp_idx_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: expected dispatch entries are queued by the
// stimulus and checked by a monitor whenever a strobed dispatch is presented.
module tb_voice_allocator;
    localparam int NV = 10;

    logic        clk = 1'b0;
    logic        reset, clk_en, i_valid;
    logic [15:0] i_data;
    logic        o_ready, o_valid, o_drop;
    logic [6:0]  o_midi;
    logic [3:0]  o_slot;
    logic [4:0]  o_active;

    int n_checks = 0;
    int n_errors = 0;
    int drop_cnt = 0;
    int tb_disp  = 0;
    logic en_d   = 1'b0;
    logic [6:0] exp_tab [NV];

    typedef struct {
        int slot;
        int midi;
        int valid;
    } disp_t;
    disp_t exp_q[$];

    always #5 clk = ~clk;

    voice_allocator #(.NVOICES(NV), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_midi(o_midi), .o_slot(o_slot), .o_valid(o_valid),
        .o_active(o_active), .o_drop(o_drop)
    );

    always @(posedge clk) en_d <= clk_en && !reset;

    always @(negedge clk) begin
        disp_t e;
        if (o_drop) drop_cnt++;
        if (en_d) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL dispatch_unexpected: got slot %0d midi %0d valid %0d, required none", o_slot, o_midi, o_valid);
            end else begin
                e = exp_q.pop_front();
                if (int'(o_slot) != e.slot || int'(o_midi) != e.midi || int'(o_valid) != e.valid) begin
                    n_errors++;
                    $display("FAIL dispatch: got slot %0d midi %0d valid %0d, required slot %0d midi %0d valid %0d",
                             o_slot, o_midi, o_valid, e.slot, e.midi, e.valid);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic on, input logic [6:0] note);
        int t;
        t = 0;
        i_valid = 1'b1;
        i_data  = {on, note, 8'h00};
        while (!o_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("push_timeout", 0, 1);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic sweep();
        disp_t e;
        for (int k = 0; k < NV; k++) begin
            e.slot  = tb_disp;
            e.midi  = int'(exp_tab[tb_disp]);
            e.valid = (exp_tab[tb_disp] != 7'd0) ? 1 : 0;
            exp_q.push_back(e);
            clk_en = 1'b1;
            @(negedge clk);
            tb_disp = (tb_disp + 1) % NV;
        end
        clk_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        tb_disp  = 0;
        drop_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ready_low;
        reset = 1'b1; clk_en = 1'b0; i_valid = 1'b0; i_data = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_midi", int'(o_midi), 0);
        chk("rst_slot", int'(o_slot), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_active", int'(o_active), 0);
        chk("rst_drop", int'(o_drop), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(o_ready), 1);

        // three notes back to back, then retrigger and a note-on 0
        ready_low = 0;
        push(1'b1, 7'd60); push(1'b1, 7'd64); push(1'b1, 7'd67);
        for (int c = 0; c < 50; c++) begin
            if (!o_ready) ready_low = 1;
            @(negedge clk);
        end
        chk("ready_stays_high", ready_low, 0);
        chk("active_three", int'(o_active), 3);
        exp_tab = '{7'd60, 7'd64, 7'd67, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        sweep();
        push(1'b1, 7'd64); push(1'b1, 7'd0);
        repeat (40) @(negedge clk);
        chk("active_retrigger", int'(o_active), 3);
        chk("drop_none_note0", drop_cnt, 0);
        sweep();

        // twelve note-ons into ten slots
        do_reset();
        for (int n = 40; n < 52; n++) push(1'b1, 7'(n));
        repeat (100) @(negedge clk);
        chk("active_full", int'(o_active), 10);
`ifdef VOICE_STEAL_EN
        chk("drops_full", drop_cnt, 0);
        exp_tab = '{7'd50, 7'd51, 7'd42, 7'd43, 7'd44, 7'd45, 7'd46, 7'd47, 7'd48, 7'd49};
`else
        chk("drops_full", drop_cnt, 2);
        exp_tab = '{7'd40, 7'd41, 7'd42, 7'd43, 7'd44, 7'd45, 7'd46, 7'd47, 7'd48, 7'd49};
`endif
        sweep();

        // note-off, note-off of an absent note, then stop-all
        do_reset();
        push(1'b1, 7'd60); push(1'b1, 7'd64); push(1'b1, 7'd67);
        push(1'b0, 7'd64);
        repeat (60) @(negedge clk);
        chk("active_after_off", int'(o_active), 2);
        push(1'b0, 7'd99);
        repeat (20) @(negedge clk);
        chk("active_off_absent", int'(o_active), 2);
        exp_tab = '{7'd60, 7'd0, 7'd67, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        sweep();
        push(1'b0, 7'h7F);
        repeat (20) @(negedge clk);
        chk("active_stop_all", int'(o_active), 0);
        exp_tab = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        sweep();

        // six consecutive commands against a four-deep FIFO (first is popped at once)
        do_reset();
        push(1'b1, 7'd20); push(1'b1, 7'd21); push(1'b0, 7'd20);
        push(1'b1, 7'd22); push(1'b1, 7'd23);
        chk("ready_full", int'(o_ready), 0);
        push(1'b0, 7'd21);
        repeat (100) @(negedge clk);
        chk("ready_drained", int'(o_ready), 1);
        chk("active_order", int'(o_active), 2);
        exp_tab = '{7'd22, 7'd0, 7'd23, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        sweep();

        // reset in the fifth scan cycle of note-on 72
        do_reset();
        push(1'b1, 7'd72);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        tb_disp = 0;
        chk("abort_ready", int'(o_ready), 1);
        repeat (30) @(negedge clk);
        chk("abort_active", int'(o_active), 0);
        exp_tab = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        sweep();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
